// File: rtl/ser_defs.sv
// Shared widths, FIFO depth, shifter state encodings and the queued word format
// used by the bit serializer, its FIFO and its input interface.
package ser_defs;

  localparam int DATA_W     = 8;
  localparam int LEN_W      = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // One queued word: how many bits to send (len+1) and the parallel data.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Upstream word handshake: valid/ready with an 8-bit word and its 3-bit length code.
interface bit_serializer_if;
  import ser_defs::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;

  modport master (output in_valid, output in_data, output in_len, input in_ready);
  modport slave  (input in_valid, input in_data, input in_len, output in_ready);

endinterface

// File: rtl/ser_fifo2.sv
// Two-entry word FIFO. Pushes into a full FIFO and pops from an empty one are
// dropped; push and pop on the same edge are both honoured.
module ser_fifo2
  import ser_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset discards every queued word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer: queues up to two words and shifts each out MSB-first
// (bit len down to bit 0) with sof/eof framing and no gap between queued words.
//
// state   | meaning
// S_IDLE  | nothing on x; waiting for the FIFO to hold a word
// S_SHIFT | x carries a payload bit; bit_cnt bits remain after this one
module bit_serializer
  import ser_defs::*;
(
  input  logic                   clk,
  input  logic                   reset,
  bit_serializer_if.slave        in_bus,
  output logic                   x,
  output logic                   x_valid,
  output logic                   sof,
  output logic                   eof,
  output logic                   busy
);

  state_t            state;
  logic [LEN_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sreg;

  entry_t            push_word;
  entry_t            head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic              push;
  logic              pop;
  logic              last_bit;
  logic              shifting_next;
  logic [CNT_W-1:0]  count_after;
  logic [DATA_W-1:0] aligned;

  assign push_word = '{len: in_bus.in_len, data: in_bus.in_data};

  ser_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshake, pop decision and next-cycle occupancy for the registered flags.
  always_comb begin
    push          = in_bus.in_valid && in_bus.in_ready && !fifo_full;
    last_bit      = (state == S_SHIFT) && (bit_cnt == '0);
    pop           = !fifo_empty && ((state == S_IDLE) || last_bit);
    count_after   = fifo_count + CNT_W'(push) - CNT_W'(pop);
    shifting_next = pop || ((state == S_SHIFT) && (bit_cnt != '0));
    // Move bit [len] of the head word up to the MSB so shifting is uniform.
    aligned       = head.data << (LEN_W'(DATA_W - 1) - head.len);
  end

  // Shifter FSM with registered stream outputs, ready and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      bit_cnt         <= '0;
      sreg            <= '0;
      x               <= 1'b0;
      x_valid         <= 1'b0;
      sof             <= 1'b0;
      eof             <= 1'b0;
      busy            <= 1'b0;
      in_bus.in_ready <= 1'b0;
    end else begin
      in_bus.in_ready <= (count_after < CNT_W'(FIFO_DEPTH));
      busy            <= shifting_next || (count_after != '0);
      if (pop) begin
        state   <= S_SHIFT;
        bit_cnt <= head.len;
        sreg    <= aligned << 1;
        x       <= aligned[DATA_W-1];
        x_valid <= 1'b1;
        sof     <= 1'b1;
        eof     <= (head.len == '0);
      end else if ((state == S_SHIFT) && (bit_cnt != '0)) begin
        bit_cnt <= bit_cnt - 1'b1;
        sreg    <= sreg << 1;
        x       <= sreg[DATA_W-1];
        x_valid <= 1'b1;
        sof     <= 1'b0;
        eof     <= (bit_cnt == LEN_W'(1));
      end else begin
        state   <= S_IDLE;
        x       <= 1'b0;
        x_valid <= 1'b0;
        sof     <= 1'b0;
        eof     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: framing, back-to-back words, FIFO
// backpressure, single-bit words, mid-word reset and a 1101 pattern stream.
module tb_bit_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        x, x_valid, sof, eof, busy;
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  hist;
  logic [15:0] det;
  int          cycles, steps, eofs, vcount;

  bit_serializer_if bus ();

  bit_serializer dut (
    .clk     (clk),
    .reset   (reset),
    .in_bus  (bus),
    .x       (x),
    .x_valid (x_valid),
    .sof     (sof),
    .eof     (eof),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [7:0] d, input logic [2:0] l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
  endtask

  // Checks n consecutive bits (expected vectors written MSB = first bit) and
  // records where a 1101 pattern completes on the valid-bit stream.
  task automatic stream(input string tag, input int n, input logic [15:0] xs,
                        input logic [15:0] sofs, input logic [15:0] eofs,
                        output logic [15:0] found);
    found = '0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {12'd0, x, x_valid, sof, eof},
            {12'd0, xs[n-1-i], 1'b1, sofs[n-1-i], eofs[n-1-i]});
      if (x_valid) begin
        hist = {hist[2:0], x};
        if (hist == 4'b1101) found[n-1-i] = 1'b1;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_len   = '0;
    hist = '0;
    step();
    step();
    check("reset_outputs", {10'd0, x, x_valid, sof, eof, busy, bus.in_ready}, 16'd0);
    reset = 1'b0;
    step();
    check("ready_after_reset", {15'd0, bus.in_ready}, 16'd1);
    check("idle_after_reset", {11'd0, x, x_valid, sof, eof, busy}, 16'd0);

    // Single word 0x0D, len 3 -> 1,1,0,1
    offer(8'h0D, 3'd3);
    step();
    bus.in_valid = 1'b0;
    check("single_gap", {11'd0, x, x_valid, sof, eof, busy}, 16'b00001);
    step();
    stream("single", 4, 16'b1101, 16'b1000, 16'b0001, det);
    check("single_idle", {11'd0, x, x_valid, sof, eof, busy}, 16'd0);

    // Back-to-back 0x0D/3 and 0x0B/3 -> 8 contiguous bits
    offer(8'h0D, 3'd3);
    step();
    check("b2b_ready", {15'd0, bus.in_ready}, 16'd1);
    offer(8'h0B, 3'd3);
    step();
    bus.in_valid = 1'b0;
    stream("b2b", 8, 16'b11011011, 16'b10001000, 16'b00010001, det);
    check("b2b_idle", {11'd0, x, x_valid, sof, eof, busy}, 16'd0);

    // Single-bit words: 0xFE/0 -> 0, 0x01/0 -> 1
    offer(8'hFE, 3'd0);
    step();
    offer(8'h01, 3'd0);
    step();
    bus.in_valid = 1'b0;
    stream("len0", 2, 16'b01, 16'b11, 16'b11, det);
    check("len0_idle", {11'd0, x, x_valid, sof, eof, busy}, 16'd0);

    // Pattern stream 0x0D/3 then 0x1B/4 -> 1101 completes at bits 3 and 7
    hist = '0;
    offer(8'h0D, 3'd3);
    step();
    offer(8'h1B, 3'd4);
    step();
    bus.in_valid = 1'b0;
    stream("pat", 9, 16'b110111011, 16'b100010000, 16'b000100001, det);
    check("pat_detect_points", det, 16'b000100010);
    check("pat_idle", {11'd0, x, x_valid, sof, eof, busy}, 16'd0);

    // Backpressure: four len-7 words with in_valid held
    offer(8'hC3, 3'd7);
    step();
    check("fill_ready_k", {15'd0, bus.in_ready}, 16'd1);
    offer(8'h5A, 3'd7);
    step();
    check("fill_first_bit", {12'd0, x, x_valid, sof, eof}, 16'b1110);
    check("fill_ready_k1", {15'd0, bus.in_ready}, 16'd1);
    offer(8'h96, 3'd7);
    step();
    check("fill_ready_full", {15'd0, bus.in_ready}, 16'd0);
    offer(8'h3C, 3'd7);
    cycles = 0;
    while (!bus.in_ready && cycles < 20) begin
      step();
      cycles++;
    end
    check("fill_stall_cycles", 16'(cycles), 16'd7);
    check("fill_w2_sof", {12'd0, x, x_valid, sof, eof}, 16'b0110);
    step();
    bus.in_valid = 1'b0;
    check("fill_w4_accepted", {15'd0, bus.in_ready}, 16'd0);
    steps = 0;
    eofs  = 0;
    while (busy && steps < 60) begin
      step();
      steps++;
      if (eof) eofs++;
    end
    check("fill_tail_eofs", 16'(eofs), 16'd3);
    check("fill_tail_cycles", 16'(steps), 16'd23);

    // Reset in the middle of 0xA5/7 with 0x77/7 queued
    offer(8'hA5, 3'd7);
    step();
    offer(8'h77, 3'd7);
    step();
    bus.in_valid = 1'b0;
    check("rst_bit0", {12'd0, x, x_valid, sof, eof}, 16'b1110);
    step();
    check("rst_bit1", {12'd0, x, x_valid, sof, eof}, 16'b0100);
    step();
    check("rst_bit2", {12'd0, x, x_valid, sof, eof}, 16'b1100);
    reset = 1'b1;
    offer(8'hFF, 3'd7);
    step();
    check("rst_outputs", {10'd0, x, x_valid, sof, eof, busy, bus.in_ready}, 16'd0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("rst_ready_back", {14'd0, busy, bus.in_ready}, 16'b01);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (x_valid || busy) vcount++;
    end
    check("rst_no_leftover_bits", 16'(vcount), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
